// File: rtl/iob_fifo_sync_asym.sv
// Single-clock FIFO, independent write/read widths, storage in external banked RAM.
// Define IOB_FIFO_SYNC_ASSERT_EN to compile in simulation-only misuse checks.
module iob_fifo_sync_asym #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W = 4,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int R = MAXDATA_W / MINDATA_W,
  localparam int R_LOG = $clog2(R),
  localparam int MINADDR_W = ADDR_W - R_LOG
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 rst_i,
  input  logic                 w_en_i,
  input  logic [W_DATA_W-1:0]  w_data_i,
  output logic                 w_full_o,
  input  logic                 r_en_i,
  output logic [R_DATA_W-1:0]  r_data_o,
  output logic                 r_empty_o,
  output logic [ADDR_W:0]      level_o,
  output logic                 ext_mem_clk_o,
  output logic                 ext_mem_arst_n_o,
  output logic                 ext_mem_cke_o,
  output logic [R-1:0]         ext_mem_w_en_o,
  output logic [MINADDR_W-1:0] ext_mem_w_addr_o,
  output logic [MAXDATA_W-1:0] ext_mem_w_data_o,
  output logic [R-1:0]         ext_mem_r_en_o,
  output logic [MINADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [MAXDATA_W-1:0] ext_mem_r_data_i
);

  localparam int W_INCR = W_DATA_W / MINDATA_W;
  localparam int R_INCR = R_DATA_W / MINDATA_W;
  localparam int CAP = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(W_INCR);
  localparam logic [ADDR_W-1:0] R_STEP = ADDR_W'(R_INCR);
  localparam logic [ADDR_W:0] W_LVL = (ADDR_W+1)'(W_INCR);
  localparam logic [ADDR_W:0] R_LVL = (ADDR_W+1)'(R_INCR);
  localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'(CAP - W_INCR);

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   level;
  logic              go;
  logic              w_acc;
  logic              r_acc;
  logic              rd_pend;
  logic [R_DATA_W-1:0] r_sel_data;

  assign ext_mem_clk_o    = clk_i;
  assign ext_mem_arst_n_o = arst_n_i;
  assign ext_mem_cke_o    = cke_i;

  assign level_o   = level;
  assign w_full_o  = level > FULL_TH;
  assign r_empty_o = level < R_LVL;

  // Accepts are gated so the RAM never sees a strobe during reset or clear.
  assign go    = arst_n_i & cke_i & ~rst_i;
  assign w_acc = go & w_en_i & ~w_full_o;
  assign r_acc = go & r_en_i & ~r_empty_o;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level   <= '0;
      rd_pend <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        w_ptr   <= '0;
        r_ptr   <= '0;
        level   <= '0;
        rd_pend <= 1'b0;
      end else begin
        if (w_acc) w_ptr <= w_ptr + W_STEP;
        if (r_acc) r_ptr <= r_ptr + R_STEP;
        level   <= level + (w_acc ? W_LVL : '0)
                         - (r_acc ? R_LVL : '0);
        rd_pend <= r_acc;
      end
    end
  end

  // RAM output lands one edge after the accept; capture it on the next.
  always_ff @(posedge clk_i) begin
    if (cke_i && rd_pend) r_data_o <= r_sel_data;
  end

  if (R == 1) begin : g_eq
    assign ext_mem_w_en_o   = w_acc;
    assign ext_mem_w_addr_o = w_ptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = r_acc;
    assign ext_mem_r_addr_o = r_ptr;
    assign r_sel_data       = ext_mem_r_data_i;
  end else if (W_DATA_W > R_DATA_W) begin : g_wwide
    logic [R_LOG-1:0] sel;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) sel <= '0;
      else if (r_acc) sel <= r_ptr[R_LOG-1:0];
    end

    assign ext_mem_w_en_o   = {R{w_acc}};
    assign ext_mem_w_addr_o = w_ptr[ADDR_W-1:R_LOG];
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = r_acc ? (R'(1) << r_ptr[R_LOG-1:0]) : '0;
    assign ext_mem_r_addr_o = r_ptr[ADDR_W-1:R_LOG];
    assign r_sel_data = ext_mem_r_data_i[sel*MINDATA_W +: MINDATA_W];
  end else begin : g_rwide
    assign ext_mem_w_en_o   = w_acc ? (R'(1) << w_ptr[R_LOG-1:0]) : '0;
    assign ext_mem_w_addr_o = w_ptr[ADDR_W-1:R_LOG];
    assign ext_mem_w_data_o = {R{w_data_i}};
    assign ext_mem_r_en_o   = {R{r_acc}};
    assign ext_mem_r_addr_o = r_ptr[ADDR_W-1:R_LOG];
    assign r_sel_data       = ext_mem_r_data_i;
  end

`ifdef IOB_FIFO_SYNC_ASSERT_EN
  initial begin
    if ((R & (R - 1)) != 0 || R_LOG > ADDR_W)
      $fatal(1, "iob_fifo_sync_asym: bad width ratio %0d", R);
  end

  always @(posedge clk_i) begin
    if (arst_n_i && cke_i && !rst_i) begin
      if (w_en_i && w_full_o) $error("iob_fifo_sync_asym: write while full");
      if (r_en_i && r_empty_o) $error("iob_fifo_sync_asym: read while empty");
    end
  end
`else
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: three width configurations, each with a banked RAM model.
// Expected read data comes from scoreboards filled as writes are accepted.
module tb_iob_fifo_sync_asym;

  logic clk;
  logic arst_n;
  logic cke;
  logic rst;

  int n_pass;
  int n_total;

  // A: W=32 R=8 ADDR_W=5
  logic        w_en_a, r_en_a, full_a, empty_a;
  logic [31:0] w_data_a;
  logic [7:0]  r_data_a;
  logic [5:0]  level_a;
  logic        xclk_a, xarst_a, xcke_a;
  logic [3:0]  mwe_a, mre_a;
  logic [2:0]  mwa_a, mra_a;
  logic [31:0] mwd_a, mrd_a;
  logic [7:0]  ram_a [4][8];

  // B: W=8 R=32 ADDR_W=5
  logic        w_en_b, r_en_b, full_b, empty_b;
  logic [7:0]  w_data_b;
  logic [31:0] r_data_b;
  logic [5:0]  level_b;
  logic        xclk_b, xarst_b, xcke_b;
  logic [3:0]  mwe_b, mre_b;
  logic [2:0]  mwa_b, mra_b;
  logic [31:0] mwd_b, mrd_b;
  logic [7:0]  ram_b [4][8];

  // C: W=8 R=8 ADDR_W=5
  logic        w_en_c, r_en_c, full_c, empty_c;
  logic [7:0]  w_data_c;
  logic [7:0]  r_data_c;
  logic [5:0]  level_c;
  logic        xclk_c, xarst_c, xcke_c;
  logic [0:0]  mwe_c, mre_c;
  logic [4:0]  mwa_c, mra_c;
  logic [7:0]  mwd_c, mrd_c;
  logic [7:0]  ram_c [32];

  logic [7:0]  bq[$];
  logic [31:0] wq[$];
  logic [7:0]  cq[$];

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(5)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .w_en_i(w_en_a), .w_data_i(w_data_a), .w_full_o(full_a),
    .r_en_i(r_en_a), .r_data_o(r_data_a), .r_empty_o(empty_a),
    .level_o(level_a),
    .ext_mem_clk_o(xclk_a), .ext_mem_arst_n_o(xarst_a),
    .ext_mem_cke_o(xcke_a),
    .ext_mem_w_en_o(mwe_a), .ext_mem_w_addr_o(mwa_a),
    .ext_mem_w_data_o(mwd_a),
    .ext_mem_r_en_o(mre_a), .ext_mem_r_addr_o(mra_a),
    .ext_mem_r_data_i(mrd_a)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(5)) u_b (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .w_en_i(w_en_b), .w_data_i(w_data_b), .w_full_o(full_b),
    .r_en_i(r_en_b), .r_data_o(r_data_b), .r_empty_o(empty_b),
    .level_o(level_b),
    .ext_mem_clk_o(xclk_b), .ext_mem_arst_n_o(xarst_b),
    .ext_mem_cke_o(xcke_b),
    .ext_mem_w_en_o(mwe_b), .ext_mem_w_addr_o(mwa_b),
    .ext_mem_w_data_o(mwd_b),
    .ext_mem_r_en_o(mre_b), .ext_mem_r_addr_o(mra_b),
    .ext_mem_r_data_i(mrd_b)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(5)) u_c (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .w_en_i(w_en_c), .w_data_i(w_data_c), .w_full_o(full_c),
    .r_en_i(r_en_c), .r_data_o(r_data_c), .r_empty_o(empty_c),
    .level_o(level_c),
    .ext_mem_clk_o(xclk_c), .ext_mem_arst_n_o(xarst_c),
    .ext_mem_cke_o(xcke_c),
    .ext_mem_w_en_o(mwe_c), .ext_mem_w_addr_o(mwa_c),
    .ext_mem_w_data_o(mwd_c),
    .ext_mem_r_en_o(mre_c), .ext_mem_r_addr_o(mra_c),
    .ext_mem_r_data_i(mrd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked RAM models with registered read.
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (mwe_a[p]) ram_a[p][mwa_a] <= mwd_a[p*8 +: 8];
      if (mre_a[p]) mrd_a[p*8 +: 8] <= ram_a[p][mra_a];
      if (mwe_b[p]) ram_b[p][mwa_b] <= mwd_b[p*8 +: 8];
      if (mre_b[p]) mrd_b[p*8 +: 8] <= ram_b[p][mra_b];
    end
    if (mwe_c[0]) ram_c[mwa_c] <= mwd_c;
    if (mre_c[0]) mrd_c <= ram_c[mra_c];
  end

  task automatic test_reset;
    arst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (level_a !== 6'd0) $display("FAIL reset_level_a got %0d want 0", level_a);
    else n_pass++;
    n_total++;
    if (empty_a !== 1'b1 || full_a !== 1'b0)
      $display("FAIL reset_flags_a got e=%b f=%b want e=1 f=0", empty_a, full_a);
    else n_pass++;
    n_total++;
    if (mwe_a !== 4'd0 || mre_a !== 4'd0)
      $display("FAIL reset_men_a got w=%b r=%b want 0", mwe_a, mre_a);
    else n_pass++;
    n_total++;
    if (level_b !== 6'd0 || empty_b !== 1'b1 || full_b !== 1'b0)
      $display("FAIL reset_b got l=%0d e=%b f=%b want 0 1 0", level_b, empty_b, full_b);
    else n_pass++;
    n_total++;
    if (level_c !== 6'd0 || empty_c !== 1'b1 || full_c !== 1'b0)
      $display("FAIL reset_c got l=%0d e=%b f=%b want 0 1 0", level_c, empty_c, full_c);
    else n_pass++;
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_wide;
    for (int i = 0; i < 8; i++) begin
      w_en_a = 1'b1;
      w_data_a = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      for (int k = 0; k < 4; k++) bq.push_back(8'(4*i+k));
      @(posedge clk); #1;
    end
    w_en_a = 1'b0;
    n_total++;
    if (full_a !== 1'b1 || level_a !== 6'd32)
      $display("FAIL fill_a got f=%b l=%0d want f=1 l=32", full_a, level_a);
    else n_pass++;
    w_en_a = 1'b1;
    w_data_a = 32'hDEADBEEF;
    #1;
    n_total++;
    if (mwe_a !== 4'd0) $display("FAIL over_wen_a got %b want 0000", mwe_a);
    else n_pass++;
    @(posedge clk); #1;
    w_en_a = 1'b0;
    n_total++;
    if (full_a !== 1'b1 || level_a !== 6'd32)
      $display("FAIL over_lvl_a got f=%b l=%0d want f=1 l=32", full_a, level_a);
    else n_pass++;
  endtask

  task automatic test_drain_wide;
    logic [7:0] exp_d;
    for (int i = 0; i <= 32; i++) begin
      r_en_a = (i < 32);
      @(posedge clk); #1;
      if (i > 0) begin
        exp_d = bq.pop_front();
        n_total++;
        if (r_data_a !== exp_d)
          $display("FAIL drain_a[%0d] got %h want %h", i-1, r_data_a, exp_d);
        else n_pass++;
      end
    end
    n_total++;
    if (empty_a !== 1'b1 || level_a !== 6'd0)
      $display("FAIL drain_end_a got e=%b l=%0d want e=1 l=0", empty_a, level_a);
    else n_pass++;
  endtask

  task automatic test_narrow_write;
    logic [31:0] acc;
    logic [31:0] exp_w;
    logic [31:0] first_w;
    logic [31:0] last_w;
    acc = '0;
    first_w = '0;
    last_w = '0;
    for (int i = 0; i < 32; i++) begin
      w_en_b = 1'b1;
      w_data_b = 8'(i);
      acc[8*(i%4) +: 8] = 8'(i);
      if (i % 4 == 3) wq.push_back(acc);
      @(posedge clk); #1;
    end
    w_en_b = 1'b0;
    n_total++;
    if (full_b !== 1'b1 || level_b !== 6'd32)
      $display("FAIL fill_b got f=%b l=%0d want f=1 l=32", full_b, level_b);
    else n_pass++;
    for (int i = 0; i <= 8; i++) begin
      r_en_b = (i < 8);
      @(posedge clk); #1;
      if (i > 0) begin
        exp_w = wq.pop_front();
        if (i == 1) first_w = r_data_b;
        if (i == 8) last_w = r_data_b;
        n_total++;
        if (r_data_b !== exp_w)
          $display("FAIL read_b[%0d] got %h want %h", i-1, r_data_b, exp_w);
        else n_pass++;
      end
    end
    n_total++;
    if (first_w !== 32'h03020100)
      $display("FAIL first_b got %h want 03020100", first_w);
    else n_pass++;
    n_total++;
    if (last_w !== 32'h1F1E1D1C)
      $display("FAIL eighth_b got %h want 1f1e1d1c", last_w);
    else n_pass++;
    n_total++;
    if (empty_b !== 1'b1 || level_b !== 6'd0)
      $display("FAIL drain_end_b got e=%b l=%0d want e=1 l=0", empty_b, level_b);
    else n_pass++;
  endtask

  task automatic test_stream;
    int lvl, sent, recvd, cyc;
    bit w, r, wacc, racc, pending;
    bit heavy_w;
    logic [7:0] exp_now, pend_exp, d;
    lvl = 0; sent = 0; recvd = 0; cyc = 0;
    pending = 1'b0; pend_exp = '0; exp_now = '0;
    while (recvd < 256 && cyc < 4000) begin
      heavy_w = ((cyc / 150) % 2) == 0;
      w = (sent < 256) &&
          ($urandom_range(0, 3) < (heavy_w ? 3 : 1));
      r = $urandom_range(0, 3) < (heavy_w ? 1 : 3);
      d = 8'($urandom);
      w_en_c = w;
      w_data_c = d;
      r_en_c = r;
      wacc = w && (lvl < 32);
      racc = r && (lvl > 0);
      if (wacc) begin cq.push_back(d); sent++; end
      if (racc) exp_now = cq.pop_front();
      lvl = lvl + int'(wacc) - int'(racc);
      @(posedge clk); #1;
      cyc++;
      if (pending) begin
        recvd++;
        n_total++;
        if (r_data_c !== pend_exp)
          $display("FAIL stream_data[%0d] got %h want %h", recvd-1, r_data_c, pend_exp);
        else n_pass++;
      end
      pending = racc;
      pend_exp = exp_now;
      n_total++;
      if (level_c !== 6'(lvl) || full_c !== (lvl == 32) || empty_c !== (lvl == 0))
        $display("FAIL stream_flags cyc %0d got l=%0d f=%b e=%b want l=%0d",
                 cyc, level_c, full_c, empty_c, lvl);
      else n_pass++;
    end
    w_en_c = 1'b0;
    r_en_c = 1'b0;
    n_total++;
    if (recvd < 256)
      $display("FAIL stream_timeout got %0d words want 256", recvd);
    else n_pass++;
  endtask

  task automatic test_simul;
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      w_en_c = 1'b1; w_data_c = 8'(8'h40 + i); cq.push_back(w_data_c);
      @(posedge clk); #1;
    end
    w_en_c = 1'b0;
    n_total++;
    if (level_c !== 6'd16) $display("FAIL lvl16 got %0d want 16", level_c);
    else n_pass++;
    w_en_c = 1'b1; r_en_c = 1'b1; w_data_c = 8'h50;
    cq.push_back(8'h50);
    exp_d = cq.pop_front();
    @(posedge clk); #1;
    w_en_c = 1'b0; r_en_c = 1'b0;
    n_total++;
    if (level_c !== 6'd16) $display("FAIL simul_lvl got %0d want 16", level_c);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (r_data_c !== exp_d) $display("FAIL simul_data got %h want %h", r_data_c, exp_d);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      w_en_c = 1'b1; w_data_c = 8'(8'h60 + i); cq.push_back(w_data_c);
      @(posedge clk); #1;
    end
    w_en_c = 1'b1; w_data_c = 8'hEE;
    #1;
    n_total++;
    if (mwe_c !== 1'b0 || full_c !== 1'b1)
      $display("FAIL full_wen_c got w=%b f=%b want w=0 f=1", mwe_c, full_c);
    else n_pass++;
    @(posedge clk); #1;
    w_en_c = 1'b0;
    n_total++;
    if (level_c !== 6'd32) $display("FAIL full_lvl_c got %0d want 32", level_c);
    else n_pass++;
    for (int i = 0; i <= 32; i++) begin
      r_en_c = (i < 32);
      @(posedge clk); #1;
      if (i > 0) begin
        exp_d = cq.pop_front();
        n_total++;
        if (r_data_c !== exp_d)
          $display("FAIL drain_c[%0d] got %h want %h", i-1, r_data_c, exp_d);
        else n_pass++;
      end
    end
    r_en_c = 1'b1;
    #1;
    n_total++;
    if (mre_c !== 1'b0 || empty_c !== 1'b1)
      $display("FAIL empty_ren_c got r=%b e=%b want r=0 e=1", mre_c, empty_c);
    else n_pass++;
    @(posedge clk); #1;
    r_en_c = 1'b0;
    n_total++;
    if (level_c !== 6'd0) $display("FAIL empty_lvl_c got %0d want 0", level_c);
    else n_pass++;
    w_en_c = 1'b1; w_data_c = 8'hA5;
    @(posedge clk); #1;
    w_en_c = 1'b0; r_en_c = 1'b1;
    @(posedge clk); #1;
    r_en_c = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (r_data_c !== 8'hA5) $display("FAIL after_empty got %h want a5", r_data_c);
    else n_pass++;
  endtask

  task automatic test_clear_hold;
    for (int i = 0; i < 3; i++) begin
      w_en_c = 1'b1; w_data_c = 8'(8'h20 + i);
      @(posedge clk); #1;
    end
    cke = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (level_c !== 6'd3) $display("FAIL cke_hold got %0d want 3", level_c);
    else n_pass++;
    cke = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; w_en_c = 1'b0;
    n_total++;
    if (level_c !== 6'd0 || empty_c !== 1'b1 || full_c !== 1'b0)
      $display("FAIL sync_clear got l=%0d e=%b f=%b want 0 1 0", level_c, empty_c, full_c);
    else n_pass++;
    w_en_c = 1'b1; w_data_c = 8'h11;
    @(posedge clk); #1;
    w_en_c = 1'b0; r_en_c = 1'b1;
    @(posedge clk); #1;
    r_en_c = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (r_data_c !== 8'h11) $display("FAIL after_clear got %h want 11", r_data_c);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    cke = 1'b1; rst = 1'b0; arst_n = 1'b1;
    w_en_a = 1'b0; r_en_a = 1'b0; w_data_a = '0;
    w_en_b = 1'b0; r_en_b = 1'b0; w_data_b = '0;
    w_en_c = 1'b0; r_en_c = 1'b0; w_data_c = '0;
    #2;
    test_reset;
    test_fill_wide;
    test_drain_wide;
    test_narrow_write;
    test_stream;
    test_simul;
    test_clear_hold;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
